// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg
//   Definitions shared by the system controller blocks (TX and RX command
//   controllers): TX sequencer state encoding and frame command codes.
package sys_ctrl_pkg;

    // TX sequencer states
    // state        | meaning
    // IDLE         | nothing in flight, both pending slots empty
    // SEND_RD      | writing the stored register-file read byte
    // SEND_ALU_LO  | writing the low byte of the stored ALU result
    // SEND_ALU_HI  | writing the high byte of the stored ALU result
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_RD     = 2'd1,
        SEND_ALU_LO = 2'd2,
        SEND_ALU_HI = 2'd3
    } tx_state_e;

    // Frame command codes decoded by the RX command controller
    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

endpackage

// File: rtl/sys_ctrl_tx.sv
// sys_ctrl_tx
//   Serialises register-file read results (one byte) and ALU results (low
//   byte then high byte) into the TX async FIFO. One pending slot per source;
//   a result arriving while its own slot is still occupied is dropped and
//   flagged on DROP.
//
//   Ports
//     CLK            system clock, rising edge
//     RST            asynchronous reset, active low
//     RdData_Valid   one-cycle pulse, RdData valid
//     RdData         register-file read data
//     ALU_OUT_Valid  one-cycle pulse, ALU_OUT valid
//     ALU_OUT        ALU result
//     FIFO_FULL      TX FIFO full, already synchronous to CLK
//     TX_P_DATA      registered byte to the FIFO
//     TX_D_VLD       registered FIFO write enable, one cycle per byte
//     Busy           frame in progress (combinational)
//     DROP           one-cycle pulse, a result was lost to overflow
//
// State table
//   state        | meaning
//   IDLE         | no byte to send, slots empty
//   SEND_RD      | send rd_buf, then ALU bytes if an ALU result is pending
//   SEND_ALU_LO  | send alu_buf low byte
//   SEND_ALU_HI  | send alu_buf high byte, then rd_buf if a read is pending
module sys_ctrl_tx
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RdData_Valid,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  ALU_OUT_Valid,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  Busy,
    output logic                  DROP
);

    tx_state_e             state_q, state_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  alu_pend_q, alu_pend_d;
    logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;
    logic [ALU_WIDTH-1:0]  alu_buf_q, alu_buf_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  drop_q, drop_d;

    logic                  rd_take;
    logic                  alu_take;

    // A slot stays pending until its last byte has been loaded, so a new
    // result for the same source is refused even on the edge that sends it.
    assign rd_take  = RdData_Valid  && !rd_pend_q;
    assign alu_take = ALU_OUT_Valid && !alu_pend_q;

    always_comb begin
        state_d    = state_q;
        rd_pend_d  = rd_pend_q;
        alu_pend_d = alu_pend_q;
        rd_buf_d   = rd_buf_q;
        alu_buf_d  = alu_buf_q;
        tx_data_d  = tx_data_q;
        tx_vld_d   = 1'b0;
        drop_d     = (RdData_Valid && rd_pend_q) || (ALU_OUT_Valid && alu_pend_q);

        if (rd_take) begin
            rd_buf_d  = RdData;
            rd_pend_d = 1'b1;
        end
        if (alu_take) begin
            alu_buf_d  = ALU_OUT;
            alu_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Read result goes first when both arrive together
                if (rd_take) begin
                    state_d = SEND_RD;
                end else if (alu_take) begin
                    state_d = SEND_ALU_LO;
                end
            end
            SEND_RD: begin
                if (!FIFO_FULL) begin
                    tx_data_d = rd_buf_q;
                    tx_vld_d  = 1'b1;
                    rd_pend_d = 1'b0;
                    // alu_pend_d includes a result captured on this same edge
                    state_d   = alu_pend_d ? SEND_ALU_LO : IDLE;
                end
            end
            SEND_ALU_LO: begin
                if (!FIFO_FULL) begin
                    tx_data_d = alu_buf_q[DATA_WIDTH-1:0];
                    tx_vld_d  = 1'b1;
                    state_d   = SEND_ALU_HI;
                end
            end
            SEND_ALU_HI: begin
                if (!FIFO_FULL) begin
                    tx_data_d  = alu_buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    tx_vld_d   = 1'b1;
                    alu_pend_d = 1'b0;
                    state_d    = rd_pend_d ? SEND_RD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            rd_pend_q  <= 1'b0;
            alu_pend_q <= 1'b0;
            rd_buf_q   <= '0;
            alu_buf_q  <= '0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_pend_q  <= rd_pend_d;
            alu_pend_q <= alu_pend_d;
            rd_buf_q   <= rd_buf_d;
            alu_buf_q  <= alu_buf_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            drop_q     <= drop_d;
        end
    end

    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign DROP      = drop_q;
    assign Busy      = (state_q != IDLE) || rd_pend_q || alu_pend_q;

endmodule
